// File: rtl/serdesphy_ana_prog_divider.sv
// Programmable integer clock divider: registered glitch-free clk_out, ratio
// updates deferred to the period wrap, and a sync strobe that restarts the period.
module serdesphy_ana_prog_divider #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = 10
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_ratio,
    input  logic             load,
    input  logic             sync,
    output logic             clk_out,
    output logic             tc_pulse,
    output logic [CNT_W-1:0] ratio_active,
    output logic             upd_ack,
    output logic             ratio_err
);
    localparam logic [CNT_W-1:0] RATIO_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] RATIO_MIN = CNT_W'(2);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] pending, pending_nxt;
    logic             pend_vld, pend_vld_nxt;
    logic [CNT_W-1:0] ratio_nxt;
    logic [CNT_W-1:0] half;
    logic             clk_out_nxt, tc_nxt, upd_ack_nxt, ratio_err_nxt;
    logic             load_ok, wrap;

    // Next-state and next-output decode; priority enable=0 > sync > wrap > count.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        pending_nxt   = pending;
        pend_vld_nxt  = pend_vld;
        ratio_nxt     = ratio_active;
        clk_out_nxt   = clk_out;
        tc_nxt        = 1'b0;
        upd_ack_nxt   = 1'b0;
        load_ok       = load && (div_ratio >= RATIO_MIN);
        ratio_err_nxt = load && (div_ratio < RATIO_MIN);
        wrap          = (cnt == (ratio_active - CNT_W'(1)));
        cnt_inc       = cnt + CNT_W'(1);
        half          = (ratio_active >> 1) + CNT_W'(ratio_active[0]);

        if (!enable || state == ST_IDLE) begin
            // Not running: a legal load takes effect immediately.
            if (load_ok) begin
                ratio_nxt   = div_ratio;
                upd_ack_nxt = 1'b1;
            end
            cnt_nxt = '0;
            if (!enable) begin
                state_nxt   = ST_IDLE;
                clk_out_nxt = 1'b0;
            end else begin
                state_nxt   = ST_RUN;
                clk_out_nxt = 1'b1;
            end
        end else begin
            if (sync || wrap) begin
                cnt_nxt     = '0;
                tc_nxt      = !sync;
                // Count restarts at 0, which is below any legal high time.
                clk_out_nxt = 1'b1;
                if (pend_vld) begin
                    ratio_nxt    = pending;
                    upd_ack_nxt  = 1'b1;
                    pend_vld_nxt = 1'b0;
                end
            end else begin
                cnt_nxt     = cnt_inc;
                clk_out_nxt = (cnt_inc < half);
            end
            // Capture after the apply above so a coincident load waits one period.
            if (load_ok) begin
                pending_nxt  = div_ratio;
                pend_vld_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            pending      <= '0;
            pend_vld     <= 1'b0;
            ratio_active <= RATIO_RST;
            clk_out      <= 1'b0;
            tc_pulse     <= 1'b0;
            upd_ack      <= 1'b0;
            ratio_err    <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            pending      <= pending_nxt;
            pend_vld     <= pend_vld_nxt;
            ratio_active <= ratio_nxt;
            clk_out      <= clk_out_nxt;
            tc_pulse     <= tc_nxt;
            upd_ack      <= upd_ack_nxt;
            ratio_err    <= ratio_err_nxt;
        end
    end

endmodule

// File: tb/tb_serdesphy_ana_prog_divider.sv
// Bench for serdesphy_ana_prog_divider: per-cycle scoreboard from a behavioural
// model plus directed per-scenario waveform checks.
module tb_serdesphy_ana_prog_divider;
    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic             clk;
        logic             tc;
        logic [CNT_W-1:0] ratio;
        logic             ack;
        logic             err;
    } obs_t;

    logic             clk_in = 1'b0;
    logic             rst, enable, load, sync;
    logic [CNT_W-1:0] div_ratio;
    logic             clk_out, tc_pulse, upd_ack, ratio_err;
    logic [CNT_W-1:0] ratio_active;

    int   errors = 0;
    int   checks = 0;
    obs_t sb[$];

    // Behavioural model state
    bit m_run, m_clk, m_pv;
    int m_ph, m_n, m_pend;

    serdesphy_ana_prog_divider #(.CNT_W(CNT_W), .DEFAULT_DIV(10)) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .enable       (enable),
        .div_ratio    (div_ratio),
        .load         (load),
        .sync         (sync),
        .clk_out      (clk_out),
        .tc_pulse     (tc_pulse),
        .ratio_active (ratio_active),
        .upd_ack      (upd_ack),
        .ratio_err    (ratio_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic model_step(input bit r, input bit en, input bit ld, input bit sy, input int dr);
        obs_t e;
        bit   legal;
        e     = '0;
        legal = ld && (dr >= 2);
        if (r) begin
            m_run = 0; m_ph = 0; m_n = 10; m_pv = 0; m_clk = 0;
        end else begin
            e.err = ld && !legal;
            if (!en || !m_run) begin
                if (legal) begin m_n = dr; e.ack = 1; end
                m_run = en; m_ph = 0; m_clk = en;
            end else begin
                if (sy || m_ph == m_n - 1) begin
                    e.tc = !sy;
                    if (m_pv) begin m_n = m_pend; m_pv = 0; e.ack = 1; end
                    m_ph = 0;
                end else begin
                    m_ph = m_ph + 1;
                end
                m_clk = (m_ph < (m_n + 1) / 2);
                if (legal) begin m_pend = dr; m_pv = 1; end
            end
        end
        e.clk   = m_clk;
        e.ratio = CNT_W'(m_n);
        sb.push_back(e);
    endtask

    task automatic cycle(input bit r, input bit en, input bit ld, input bit sy, input logic [CNT_W-1:0] dr);
        @(negedge clk_in);
        rst = r; enable = en; load = ld; sync = sy; div_ratio = dr;
        model_step(r, en, ld, sy, int'(dr));
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, o;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, (i == 2), (i == 1), 1'b0, 8'd3);
            e = sb.pop_front();
            o = {clk_out, tc_pulse, ratio_active, upd_ack, ratio_err};
            checks++;
            if (o !== e) begin errors++; $display("FAIL reset_sb i=%0d got=%h exp=%h", i, o, e); end
            checks++;
            if (o !== {1'b0, 1'b0, 8'd10, 1'b0, 1'b0}) begin
                errors++; $display("FAIL reset_state i=%0d got=%h exp=%h", i, o, {1'b0, 1'b0, 8'd10, 1'b0, 1'b0});
            end
        end
    endtask

    task automatic test_default_div();
        obs_t e, o;
        logic xc, xt;
        for (int i = -1; i < 30; i++) begin
            cycle(1'b0, (i >= 0), 1'b0, 1'b0, 8'd0);
            e = sb.pop_front();
            o = {clk_out, tc_pulse, ratio_active, upd_ack, ratio_err};
            checks++;
            if (o !== e) begin errors++; $display("FAIL default_sb i=%0d got=%h exp=%h", i, o, e); end
            if (i >= 0) begin
                xc = ((i % 10) < 5);
                xt = (i > 0) && (i % 10 == 0);
                checks++;
                if ({clk_out, tc_pulse} !== {xc, xt}) begin
                    errors++; $display("FAIL default_wave i=%0d got=%b%b exp=%b%b", i, clk_out, tc_pulse, xc, xt);
                end
            end
        end
    endtask

    task automatic test_load_idle();
        obs_t e, o;
        logic xc, xt, xa;
        for (int i = -2; i < 12; i++) begin
            cycle(1'b0, (i >= 0), (i == -1), 1'b0, 8'd3);
            e = sb.pop_front();
            o = {clk_out, tc_pulse, ratio_active, upd_ack, ratio_err};
            checks++;
            if (o !== e) begin errors++; $display("FAIL load_idle_sb i=%0d got=%h exp=%h", i, o, e); end
            if (i >= -1) begin
                xc = (i >= 0) && ((i % 3) < 2);
                xt = (i > 0) && (i % 3 == 0);
                xa = (i == -1);
                checks++;
                if ({clk_out, tc_pulse, upd_ack, ratio_active} !== {xc, xt, xa, 8'd3}) begin
                    errors++;
                    $display("FAIL load_idle_wave i=%0d got=%b%b%b r=%0d exp=%b%b%b r=3",
                             i, clk_out, tc_pulse, upd_ack, ratio_active, xc, xt, xa);
                end
            end
        end
    endtask

    task automatic test_load_running();
        obs_t e, o;
        logic xc, xa;
        logic [CNT_W-1:0] xr;
        for (int i = -2; i < 22; i++) begin
            cycle(1'b0, (i >= 0), (i == -1 || i == 3), 1'b0, (i == 3) ? 8'd4 : 8'd10);
            e = sb.pop_front();
            o = {clk_out, tc_pulse, ratio_active, upd_ack, ratio_err};
            checks++;
            if (o !== e) begin errors++; $display("FAIL load_run_sb i=%0d got=%h exp=%h", i, o, e); end
            if (i >= 0) begin
                xr = (i >= 10) ? 8'd4 : 8'd10;
                xa = (i == 10);
                xc = (i < 10) ? (i < 5) : (((i - 10) % 4) < 2);
                checks++;
                if ({clk_out, upd_ack, ratio_active} !== {xc, xa, xr}) begin
                    errors++;
                    $display("FAIL load_run_wave i=%0d got=%b%b r=%0d exp=%b%b r=%0d",
                             i, clk_out, upd_ack, ratio_active, xc, xa, xr);
                end
            end
        end
    endtask

    task automatic test_illegal_load();
        obs_t e, o;
        logic xc, xe;
        logic [CNT_W-1:0] dr;
        for (int i = -2; i < 25; i++) begin
            dr = (i == 3) ? 8'd0 : (i == 6) ? 8'd1 : 8'd10;
            cycle(1'b0, (i >= 0), (i == -1 || i == 3 || i == 6), 1'b0, dr);
            e = sb.pop_front();
            o = {clk_out, tc_pulse, ratio_active, upd_ack, ratio_err};
            checks++;
            if (o !== e) begin errors++; $display("FAIL illegal_sb i=%0d got=%h exp=%h", i, o, e); end
            if (i >= 0) begin
                xc = ((i % 10) < 5);
                xe = (i == 3 || i == 6);
                checks++;
                if ({clk_out, ratio_err, upd_ack, ratio_active} !== {xc, xe, 1'b0, 8'd10}) begin
                    errors++;
                    $display("FAIL illegal_wave i=%0d got=%b%b%b r=%0d exp=%b%b0 r=10",
                             i, clk_out, ratio_err, upd_ack, ratio_active, xc, xe);
                end
            end
        end
    endtask

    task automatic test_sync();
        obs_t e, o;
        logic xc, xt;
        for (int i = -2; i < 21; i++) begin
            cycle(1'b0, (i >= 0), (i == -1), (i == 8), 8'd10);
            e = sb.pop_front();
            o = {clk_out, tc_pulse, ratio_active, upd_ack, ratio_err};
            checks++;
            if (o !== e) begin errors++; $display("FAIL sync_sb i=%0d got=%h exp=%h", i, o, e); end
            if (i >= 0) begin
                xc = (i < 8) ? (i < 5) : (((i - 8) % 10) < 5);
                xt = (i == 18);
                checks++;
                if ({clk_out, tc_pulse} !== {xc, xt}) begin
                    errors++; $display("FAIL sync_wave i=%0d got=%b%b exp=%b%b", i, clk_out, tc_pulse, xc, xt);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        logic xa, xt;
        logic [CNT_W-1:0] xr, dr;
        for (int i = -2; i < 24; i++) begin
            dr = (i == 3) ? 8'd6 : (i == 5) ? 8'd5 : (i == 10) ? 8'd3 : 8'd10;
            cycle(1'b0, (i >= 0), (i == -1 || i == 3 || i == 5 || i == 10), 1'b0, dr);
            e = sb.pop_front();
            o = {clk_out, tc_pulse, ratio_active, upd_ack, ratio_err};
            checks++;
            if (o !== e) begin errors++; $display("FAIL b2b_sb i=%0d got=%h exp=%h", i, o, e); end
            if (i >= 0) begin
                xr = (i < 10) ? 8'd10 : (i < 15) ? 8'd5 : 8'd3;
                xa = (i == 10 || i == 15);
                xt = (i == 10 || i == 15 || (i > 15 && ((i - 15) % 3 == 0)));
                checks++;
                if ({upd_ack, tc_pulse, ratio_active} !== {xa, xt, xr}) begin
                    errors++;
                    $display("FAIL b2b_wave i=%0d got=%b%b r=%0d exp=%b%b r=%0d",
                             i, upd_ack, tc_pulse, ratio_active, xa, xt, xr);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t e, o;
        logic xc, xt;
        for (int i = -2; i < 26; i++) begin
            cycle((i == 7), (i >= 0), (i == -1 || i == 2), 1'b0, (i == 2) ? 8'd6 : 8'd10);
            e = sb.pop_front();
            o = {clk_out, tc_pulse, ratio_active, upd_ack, ratio_err};
            checks++;
            if (o !== e) begin errors++; $display("FAIL rst_mid_sb i=%0d got=%h exp=%h", i, o, e); end
            if (i == 7) begin
                checks++;
                if (o !== {1'b0, 1'b0, 8'd10, 1'b0, 1'b0}) begin
                    errors++; $display("FAIL rst_mid_clear got=%h exp=%h", o, {1'b0, 1'b0, 8'd10, 1'b0, 1'b0});
                end
            end else if (i >= 8) begin
                xc = (((i - 8) % 10) < 5);
                xt = (i == 18);
                checks++;
                if ({clk_out, tc_pulse, upd_ack, ratio_active} !== {xc, xt, 1'b0, 8'd10}) begin
                    errors++;
                    $display("FAIL rst_mid_wave i=%0d got=%b%b%b r=%0d exp=%b%b0 r=10",
                             i, clk_out, tc_pulse, upd_ack, ratio_active, xc, xt);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; load = 1'b0; sync = 1'b0; div_ratio = '0;
        m_run = 0; m_clk = 0; m_pv = 0; m_ph = 0; m_n = 10; m_pend = 0;
        test_reset();
        test_default_div();
        test_load_idle();
        test_load_running();
        test_illegal_load();
        test_sync();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serdesphy_ana_prog_divider.md
SERDESPHY_ANA_PROG_DIVIDER -- requirements
Module: serdesphy_ana_prog_divider

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of counter and ratio fields.
REQ-002 SHALL have parameter DEFAULT_DIV, default 10, active ratio after reset (legal range 2..2^CNT_W-1).
REQ-003 SHALL have port clk_in  input  1  single clock, VCO-rate input; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  run divider when high; hold idle when low.
REQ-006 SHALL have port div_ratio  input  CNT_W  requested divide ratio N.
REQ-007 SHALL have port load  input  1  one-cycle strobe capturing div_ratio.
REQ-008 SHALL have port sync  input  1  phase-realign strobe; restarts output period.
REQ-009 SHALL have port clk_out  output  1  registered divided clock, period N clk_in cycles.
REQ-010 SHALL have port tc_pulse  output  1  one-cycle registered pulse at each period wrap.
REQ-011 SHALL have port ratio_active  output  CNT_W  ratio currently in use.
REQ-012 SHALL have port upd_ack  output  1  one-cycle pulse on the cycle a new ratio takes effect.
REQ-013 SHALL have port ratio_err  output  1  one-cycle pulse when load carries an illegal ratio.

Function
REQ-014 SHALL hold internal counter cnt (CNT_W bits), running flag, pending ratio and pending-valid flag.
REQ-015 SHALL, while enable=0: cnt=0, running=0, clk_out=0, tc_pulse=0.
REQ-016 SHALL, on first edge with enable=1 and running=0: running<=1, cnt<=0, clk_out<=1, tc_pulse stays 0.
REQ-017 SHALL, while running: cnt<=0 if cnt==N-1 else cnt+1 (N = ratio_active); no other values reachable.
REQ-018 SHALL register clk_out <= (next cnt < H), H = (N+1)>>1; N even -> 50% duty, N odd -> high one cycle longer than low.
REQ-019 SHALL assert tc_pulse for exactly the cycle in which cnt returns to 0 by wrap (not on start or sync).
REQ-020 SHALL treat load with div_ratio<2 as illegal: ratio_err pulses next cycle, pending state unchanged.
REQ-021 SHALL, on legal load while running, store pending ratio; later loads overwrite (latest wins).
REQ-022 SHALL apply pending ratio on the wrap edge (cnt==N-1): ratio_active<=pending, H recomputed from new ratio for that edge, upd_ack pulses, pending cleared.
REQ-023 SHALL, when load coincides with a wrap edge, apply the previously pending value (if any) now and the new value at the following wrap.
REQ-024 SHALL, on legal load while not running, update ratio_active on that edge and pulse upd_ack; no pending used.
REQ-025 SHALL, on sync while running: cnt<=0, clk_out<=1, tc_pulse=0, pending ratio applied with upd_ack.
REQ-026 SHALL give priority rst > enable=0 > sync > wrap > count; sync while not running is ignored.
REQ-027 SHALL produce no clk_out glitches: clk_out changes only at clk_in rising edges.

Reset
REQ-028 SHALL, with rst=1 at a rising edge: cnt=0, running=0, clk_out=0, tc_pulse=0, upd_ack=0, ratio_err=0, pending cleared, ratio_active=DEFAULT_DIV.
REQ-029 SHALL abort any period or pending update on reset mid-operation; first enabled edge after reset starts per REQ-016.

Verification
REQ-030 SHALL cover: reset, enable=1 at default N=10 -> clk_out 5 high/5 low, tc_pulse every 10 cycles, first tc 10 cycles after start.
REQ-031 SHALL cover: load N=3 while idle, enable -> ratio_active=3, upd_ack once, clk_out 2 high/1 low repeating.
REQ-032 SHALL cover: running N=10, load N=4 at cnt=2 -> current period completes 10 cycles, upd_ack at wrap, then 2 high/2 low.
REQ-033 SHALL cover: load div_ratio=0 and =1 -> ratio_err pulses, ratio_active unchanged, output period unchanged.
REQ-034 SHALL cover: sync at cnt=7 (N=10) -> next cycle cnt=0, clk_out=1, no tc_pulse, next tc_pulse 10 cycles later.
REQ-035 SHALL cover: rst asserted at cnt=6 with pending N=6 -> all outputs 0, ratio_active=10, pending discarded.
